// File: rtl/acsi_cmd_queue_pkg.sv
// Shared types, constants and helpers for the ACSI command queue.
package acsi_pkg;

  localparam logic [4:0] ICD_CODE   = 5'h1F;
  localparam int         IDX_TGT    = 16;
  localparam int         IDX_LEN    = 17;
  localparam int         MAXLEN_CAP = 16;

  typedef enum logic {
    ASM_IDLE   = 1'b0,
    ASM_ACTIVE = 1'b1
  } asm_state_t;

  // Storage is always sized for the largest command; entries shorter than
  // MAXLEN_CAP simply leave the upper bytes unused.
  typedef struct packed {
    logic [MAXLEN_CAP-1:0][7:0] bytes;
    logic [2:0]                 target;
    logic [4:0]                 len;
  } cmd_entry_t;

  // Command length implied by the opcode byte, clamped to the stored length.
  function automatic logic [4:0] cmd_len(input logic [7:0] byte0, input int maxlen);
    logic [4:0] l;
    if (byte0 <= 8'h1F)                        l = 5'd6;
    else if (byte0 <= 8'h5F)                   l = 5'd10;
    else if (byte0 >= 8'h80 && byte0 <= 8'h9F) l = 5'd16;
    else                                       l = 5'd12;
    if (int'(l) > maxlen) l = 5'(maxlen);
    return l;
  endfunction

endpackage

// File: rtl/acsi_cmd_queue_fifo.sv
// Small synchronous FIFO of complete command entries; push and pop may
// happen together, and a pop on a full FIFO makes room for the same-cycle push.
module acsi_cmd_fifo
  import acsi_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          push,
  input  logic          pop,
  input  cmd_entry_t    din,
  output cmd_entry_t    dout,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  cmd_entry_t    mem_q [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push_ok, pop_ok;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (int'(p) == DEPTH - 1) ? '0 : p + PW'(1);
  endfunction

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));
  assign count = count_q;
  assign dout  = mem_q[rd_ptr_q];

  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);

  // Pointer and occupancy update.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (pop_ok)  rd_ptr_d = ptr_inc(rd_ptr_q);
    if (push_ok) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (push_ok && !pop_ok)      count_d = count_q + CW'(1);
    else if (pop_ok && !push_ok) count_d = count_q - CW'(1);
  end

  // Control registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents are only meaningful below count, so no reset.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/acsi_cmd_queue.sv
// ACSI command collector: assembles CPU-written command blocks and queues
// complete commands for the IO controller, which retires them with ack/nak.
module acsi_cmd_queue
  import acsi_pkg::*;
#(
  parameter int TARGETS = 8,
  parameter int DEPTH   = 2,
  parameter int MAXLEN  = 16
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       clk_en,
  input  logic [TARGETS-1:0]         enable,
  input  logic                       cpu_a1,
  input  logic                       cpu_sel,
  input  logic                       cpu_rw,
  input  logic [7:0]                 cpu_din,
  output logic [7:0]                 cpu_dout,
  output logic                       irq,
  input  logic [7:0]                 dma_status,
  input  logic                       dma_ack,
  input  logic                       dma_nak,
  input  logic [4:0]                 io_sel,
  output logic [7:0]                 io_byte,
  output logic                       io_valid,
  output logic [$clog2(DEPTH+1)-1:0] io_count,
  output logic [7:0]                 drop_count
);

  localparam int CW = $clog2(DEPTH + 1);

  asm_state_t                 state_q, state_d;
  logic                       sel_d_q, sel_d_d;
  logic [4:0]                 cnt_q, cnt_d;
  logic [2:0]                 tgt_q, tgt_d;
  logic [MAXLEN_CAP-1:0][7:0] bytes_q, bytes_d;
  logic                       irq_q, irq_d;
  logic [7:0]                 drop_q, drop_d;

  logic       cpu_req, cpu_act, cpu_wr;
  logic [7:0] en_mask;
  logic [4:0] len_cur;
  logic       irq_set_cpu;
  logic       push, pop, ack_eff;
  logic       fifo_full, fifo_empty;
  cmd_entry_t push_entry, head;

  assign cpu_dout   = dma_status;
  assign irq        = irq_q;
  assign drop_count = drop_q;
  assign io_valid   = ~fifo_empty;

  assign cpu_req = cpu_sel & ~sel_d_q;
  assign cpu_act = clk_en & cpu_req;
  assign cpu_wr  = cpu_act & ~cpu_rw;
  assign pop     = (dma_ack | dma_nak) & ~fifo_empty;
  assign ack_eff = dma_ack & ~fifo_empty;

  // Zero-extend the enable mask so targets beyond TARGETS read as disabled.
  always_comb begin
    en_mask = '0;
    en_mask[TARGETS-1:0] = enable;
  end

  // Command assembly, push decision and irq priority.
  always_comb begin
    state_d     = state_q;
    sel_d_d     = sel_d_q;
    cnt_d       = cnt_q;
    tgt_d       = tgt_q;
    bytes_d     = bytes_q;
    irq_d       = irq_q;
    drop_d      = drop_q;
    irq_set_cpu = 1'b0;
    push        = 1'b0;

    if (clk_en) sel_d_d = cpu_sel;

    if (cpu_wr && !cpu_a1) begin
      tgt_d = cpu_din[7:5];
      if (cpu_din[4:0] == ICD_CODE) begin
        cnt_d = 5'd0;
      end else begin
        bytes_d[0] = {3'b000, cpu_din[4:0]};
        cnt_d      = 5'd1;
      end
      state_d     = ASM_ACTIVE;
      irq_set_cpu = en_mask[cpu_din[7:5]];
    end else if (cpu_wr && cpu_a1) begin
      if (cnt_q < 5'(MAXLEN)) bytes_d[cnt_q[3:0]] = cpu_din;
      cnt_d = (cnt_q == 5'd31) ? 5'd31 : cnt_q + 5'd1;
      if (state_q == ASM_ACTIVE && en_mask[tgt_q]) begin
        if (cnt_q < len_cur - 5'd1) begin
          irq_set_cpu = 1'b1;
        end else if (cnt_q == len_cur - 5'd1) begin
          state_d = ASM_IDLE;
          if (!fifo_full || pop) push = 1'b1;
          else if (drop_q != 8'hFF) drop_d = drop_q + 8'd1;
        end
      end
    end

    if (irq_set_cpu)  irq_d = 1'b1;
    else if (cpu_act) irq_d = 1'b0;
    else if (ack_eff) irq_d = 1'b1;
  end

  // The opcode byte may be written in the same cycle (ICD index 0), so use
  // the next-state copy for both the length and the pushed data.
  assign len_cur    = cmd_len(bytes_d[0], MAXLEN);
  assign push_entry = '{bytes: bytes_d, target: tgt_q, len: len_cur};

  // Assembly and status registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ASM_IDLE;
      sel_d_q <= 1'b0;
      cnt_q   <= '0;
      tgt_q   <= '0;
      bytes_q <= '0;
      irq_q   <= 1'b0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      sel_d_q <= sel_d_d;
      cnt_q   <= cnt_d;
      tgt_q   <= tgt_d;
      bytes_q <= bytes_d;
      irq_q   <= irq_d;
      drop_q  <= drop_d;
    end
  end

  acsi_cmd_fifo #(.DEPTH(DEPTH), .CW(CW)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .pop     (pop),
    .din     (push_entry),
    .dout    (head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (io_count)
  );

  // IO-side read mux over the head entry.
  always_comb begin
    io_byte = 8'h00;
    if (!fifo_empty) begin
      if (io_sel < 5'(MAXLEN))            io_byte = head.bytes[io_sel[3:0]];
      else if (io_sel == 5'(IDX_TGT))     io_byte = {head.target, 4'b0000, 1'b1};
      else if (io_sel == 5'(IDX_LEN))     io_byte = {3'b000, head.len};
    end
  end

endmodule

// File: tb/tb_acsi_cmd_queue.sv
// Directed bench for acsi_cmd_queue with default parameters.
module tb_acsi_cmd_queue;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       clk_en;
  logic [7:0] enable;
  logic       cpu_a1, cpu_sel, cpu_rw;
  logic [7:0] cpu_din, cpu_dout;
  logic       irq;
  logic [7:0] dma_status;
  logic       dma_ack, dma_nak;
  logic [4:0] io_sel;
  logic [7:0] io_byte;
  logic       io_valid;
  logic [1:0] io_count;
  logic [7:0] drop_count;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  acsi_cmd_queue #(.TARGETS(8), .DEPTH(2), .MAXLEN(16)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .clk_en     (clk_en),
    .enable     (enable),
    .cpu_a1     (cpu_a1),
    .cpu_sel    (cpu_sel),
    .cpu_rw     (cpu_rw),
    .cpu_din    (cpu_din),
    .cpu_dout   (cpu_dout),
    .irq        (irq),
    .dma_status (dma_status),
    .dma_ack    (dma_ack),
    .dma_nak    (dma_nak),
    .io_sel     (io_sel),
    .io_byte    (io_byte),
    .io_valid   (io_valid),
    .io_count   (io_count),
    .drop_count (drop_count)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One CPU access: select for one cycle, then deselect so the next access
  // produces a fresh request edge.
  task automatic cpu_access(input logic a1, input logic rw, input logic [7:0] din);
    @(negedge clk);
    cpu_sel = 1'b1; cpu_a1 = a1; cpu_rw = rw; cpu_din = din;
    @(negedge clk);
    cpu_sel = 1'b0;
  endtask

  task automatic retire(input logic ack, input logic nak);
    @(negedge clk);
    dma_ack = ack; dma_nak = nak;
    @(negedge clk);
    dma_ack = 1'b0; dma_nak = 1'b0;
  endtask

  task automatic io_read(input logic [4:0] sel, output logic [7:0] val);
    io_sel = sel;
    #1 val = io_byte;
  endtask

  task automatic send_cmd6(input logic [7:0] first, input logic [7:0] b1, input logic [7:0] b5);
    cpu_access(1'b0, 1'b0, first);
    cpu_access(1'b1, 1'b0, b1);
    cpu_access(1'b1, 1'b0, 8'h00);
    cpu_access(1'b1, 1'b0, 8'h00);
    cpu_access(1'b1, 1'b0, 8'h00);
    cpu_access(1'b1, 1'b0, b5);
  endtask

  logic [7:0] rd;
  logic [7:0] seq1 [5];

  initial begin
    reset_n = 1'b0; clk_en = 1'b1; enable = 8'hFF;
    cpu_a1 = 1'b0; cpu_sel = 1'b0; cpu_rw = 1'b0; cpu_din = 8'h00;
    dma_status = 8'h5A; dma_ack = 1'b0; dma_nak = 1'b0; io_sel = 5'd0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    // Reset state
    check_val("rst_irq", irq, 0);
    check_val("rst_valid", io_valid, 0);
    check_val("rst_count", io_count, 0);
    check_val("rst_drop", drop_count, 0);
    io_read(5'd16, rd); check_val("rst_iobyte", rd, 8'h00);
    check_val("cpu_dout", cpu_dout, 8'h5A);

    // Basic 6-byte command 08 00 00 00 01 00
    seq1 = '{8'h00, 8'h00, 8'h00, 8'h01, 8'h00};
    cpu_access(1'b0, 1'b0, 8'h08);
    check_val("c1_irq_b0", irq, 1);
    for (int i = 0; i < 4; i++) begin
      cpu_access(1'b1, 1'b0, seq1[i]);
      check_val($sformatf("c1_irq_b%0d", i + 1), irq, 1);
    end
    cpu_access(1'b1, 1'b0, seq1[4]);
    check_val("c1_irq_done", irq, 0);
    check_val("c1_valid", io_valid, 1);
    io_read(5'd17, rd); check_val("c1_len", rd, 8'h06);
    io_read(5'd16, rd); check_val("c1_tgt", rd, 8'h01);
    io_read(5'd0, rd);  check_val("c1_b0", rd, 8'h08);
    io_read(5'd4, rd);  check_val("c1_b4", rd, 8'h01);
    io_read(5'd18, rd); check_val("c1_idx18", rd, 8'h00);
    retire(1'b0, 1'b1);
    check_val("c1_nak_valid", io_valid, 0);
    check_val("c1_nak_irq", irq, 0);

    // ICD command to target 1, opcode 25 -> 10 bytes
    cpu_access(1'b0, 1'b0, 8'h3F);
    check_val("icd_irq_first", irq, 1);
    cpu_access(1'b1, 1'b0, 8'h25);
    for (int i = 1; i < 9; i++) cpu_access(1'b1, 1'b0, 8'h00);
    check_val("icd_irq_b8", irq, 1);
    check_val("icd_valid_early", io_valid, 0);
    cpu_access(1'b1, 1'b0, 8'h77);
    check_val("icd_valid", io_valid, 1);
    check_val("icd_irq_done", irq, 0);
    io_read(5'd17, rd); check_val("icd_len", rd, 8'h0A);
    io_read(5'd16, rd); check_val("icd_tgt", rd, 8'h21);
    io_read(5'd0, rd);  check_val("icd_b0", rd, 8'h25);
    io_read(5'd9, rd);  check_val("icd_b9", rd, 8'h77);
    retire(1'b1, 1'b0);
    check_val("icd_ack_irq", irq, 1);
    check_val("icd_ack_valid", io_valid, 0);
    cpu_access(1'b0, 1'b1, 8'h00);
    check_val("read_clr_irq", irq, 0);
    retire(1'b1, 1'b0);
    check_val("ack_empty_irq", irq, 0);

    // Overflow: three commands into a 2-deep FIFO
    send_cmd6(8'h08, 8'hA1, 8'hB1);
    send_cmd6(8'h09, 8'hA2, 8'hB2);
    check_val("ovf_count2", io_count, 2);
    check_val("ovf_drop0", drop_count, 0);
    send_cmd6(8'h0A, 8'hA3, 8'hB3);
    check_val("ovf_count", io_count, 2);
    check_val("ovf_drop", drop_count, 1);
    check_val("ovf_irq", irq, 0);
    io_read(5'd0, rd); check_val("ovf_head_b0", rd, 8'h08);
    retire(1'b0, 1'b1);
    check_val("ovf_nak_count", io_count, 1);
    check_val("ovf_nak_irq", irq, 0);
    io_read(5'd1, rd); check_val("ovf_head2_b1", rd, 8'hA2);
    retire(1'b1, 1'b1);
    check_val("ovf_both_count", io_count, 0);
    check_val("ovf_both_irq", irq, 1);

    // Disabled target 5
    enable = 8'hDF;
    cpu_access(1'b0, 1'b0, 8'hA0);
    check_val("dis_irq_b0", irq, 0);
    for (int i = 0; i < 5; i++) cpu_access(1'b1, 1'b0, 8'h00);
    check_val("dis_irq_end", irq, 0);
    check_val("dis_valid", io_valid, 0);
    enable = 8'hFF;

    // Abort a partial command and restart
    cpu_access(1'b0, 1'b0, 8'h08);
    for (int i = 0; i < 3; i++) cpu_access(1'b1, 1'b0, 8'hEE);
    cpu_access(1'b0, 1'b0, 8'h03);
    cpu_access(1'b1, 1'b0, 8'h11);
    cpu_access(1'b1, 1'b0, 8'h22);
    cpu_access(1'b1, 1'b0, 8'h33);
    cpu_access(1'b1, 1'b0, 8'h44);
    check_val("abort_valid_early", io_valid, 0);
    cpu_access(1'b1, 1'b0, 8'h55);
    check_val("abort_count", io_count, 1);
    io_read(5'd0, rd); check_val("abort_b0", rd, 8'h03);
    io_read(5'd1, rd); check_val("abort_b1", rd, 8'h11);
    io_read(5'd5, rd); check_val("abort_b5", rd, 8'h55);

    // Reset with two queued entries and irq pending
    send_cmd6(8'h08, 8'h00, 8'h00);
    cpu_access(1'b0, 1'b0, 8'h08);
    check_val("pre_rst_count", io_count, 2);
    check_val("pre_rst_irq", irq, 1);
    check_val("pre_rst_drop", drop_count, 1);
    @(negedge clk); reset_n = 1'b0;
    @(negedge clk); reset_n = 1'b1;
    check_val("rst2_valid", io_valid, 0);
    check_val("rst2_count", io_count, 0);
    check_val("rst2_irq", irq, 0);
    check_val("rst2_drop", drop_count, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/acsi_cmd_queue.md
Name: acsi_cmd_queue

Overview:
- Parametrised successor of the ACSI command-byte collector for the Atari ST core.
- Assembles ACSI/ICD command blocks written by the CPU and queues up to DEPTH complete commands for the IO controller. The IO controller reads each queued command by byte index and retires it with ack or nak.
- Adds over the single-command collector: configurable target count and maximum command length, a command FIFO, overflow/drop accounting, and explicit partial-command abort.
- Sits between the DMA/ACSI register decode on the CPU side and the IO-controller status/handshake channel.

Parameters:
- TARGETS, 8, number of addressable targets; range 1..8. Targets >= TARGETS are always treated as disabled.
- DEPTH, 2, number of complete commands held in the FIFO; power of two, >= 1.
- MAXLEN, 16, bytes stored per command; range 6..16. Bytes beyond MAXLEN are discarded.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  synchronous active-low reset.
- clk_en  in  1  CPU-side clock enable; qualifies CPU bus sampling.
- enable  in  TARGETS  per-target enable mask.
- cpu_a1  in  1  0 = first command byte, 1 = further bytes.
- cpu_sel  in  1  ACSI register select.
- cpu_rw  in  1  1 = read, 0 = write.
- cpu_din  in  8  CPU write data.
- cpu_dout  out  8  CPU read data; always equals dma_status.
- irq  out  1  ACSI interrupt to the CPU.
- dma_status  in  8  status byte supplied by the IO controller.
- dma_ack  in  1  IO controller accepts the head command.
- dma_nak  in  1  IO controller rejects the head command (no device).
- io_sel  in  5  byte index into the head command.
- io_byte  out  8  selected byte of the head command.
- io_valid  out  1  FIFO is not empty.
- io_count  out  $clog2(DEPTH+1)  number of queued commands.
- drop_count  out  8  saturating count of commands dropped because the FIFO was full.

Behaviour:
- Reset (reset_n = 0 at a clk edge): irq = 0; FIFO empty (io_valid = 0, io_count = 0); drop_count = 0; assembly idle; assembly counter = 0; stored target = 0. io_byte follows the empty-FIFO rule below.
- CPU request:
  - cpu_req = cpu_sel & ~cpu_sel_d, where cpu_sel_d is cpu_sel registered on clk_en.
  - CPU actions occur only on cycles where clk_en & cpu_req.
- First byte (write, cpu_a1 = 0):
  - target = din[7:5].
  - If din[4:0] == 5'h1F (ICD): counter = 0.
  - Otherwise: byte0 = {3'b0, din[4:0]}; counter = 1.
  - Any partially assembled command is silently discarded.
  - Assembly state becomes ACTIVE.
  - irq is set if the target is enabled.
- Further bytes (write, cpu_a1 = 1, ACTIVE):
  - Store din at index counter if counter < MAXLEN; otherwise drop the byte.
  - counter increments, saturating at 31.
  - If the target is enabled and counter < len-1: set irq.
  - If the target is enabled and counter == len-1: the command is complete. Push {bytes, target, len} and return to IDLE.
    - If the FIFO is full, do not push, increment drop_count (saturating at 255), and do not set irq.
  - Further-byte writes while IDLE, or to a disabled target, are stored but never push and never set irq.
- Command length (len) from byte0:
  - 00–1F: 6
  - 20–5F: 10
  - 80–9F: 16
  - all other values: 12
  - len is clamped to MAXLEN.
- IO read port (combinational from the head entry):
  - io_sel < MAXLEN: selected command byte.
  - io_sel == 16: {target, 4'b0, io_valid}.
  - io_sel == 17: {3'b0, len}.
  - Any other index: 8'h00.
  - FIFO empty: io_byte = 0.
- Retire:
  - dma_ack while io_valid: pop the head entry; set irq.
  - dma_nak while io_valid: pop the head entry; irq unchanged.
  - ack and nak together: treated as ack.
  - ack or nak while the FIFO is empty: ignored.
- Simultaneous push and pop in one cycle: both take effect; count unchanged. When full, a pop frees a slot in the same cycle, so the push succeeds.
- irq priority within one cycle, highest first:
  1. CPU write that sets irq
  2. clear on any cpu_req (read or write)
  3. set on ack
- Latency:
  - A push is visible on io_valid/io_byte on the cycle after the completing write.
  - A pop advances the head on the next cycle.

Decomposition:
- Package acsi_pkg holds:
  - ICD escape code 5'h1F.
  - Status index constants IDX_TGT = 16 and IDX_LEN = 17.
  - Function cmd_len(byte0, maxlen).
  - Entry struct: bytes[MAXLEN], target[2:0], len[4:0].
- Sub-module acsi_cmd_fifo: DEPTH-entry synchronous FIFO of entry structs with push, pop, full, empty and count, supporting simultaneous push and pop.

Test Plan:
- Reset, enable = 8'hFF, write a1=0 din 8'h08, then five a1=1 writes 00 00 00 01 00 → irq after each of bytes 0–4 (cleared by each cpu_req); after byte 5, io_valid = 1, io_sel 17 → 8'h06, io_sel 16 → 8'h01, io_sel 0 → 8'h08.
- ICD: din 8'h3F, then a1=1 bytes 25 00 … (10 bytes total) → len 10, target 1, byte0 = 8'h25; dma_ack → irq = 1, io_valid = 0.
- DEPTH=2: queue three 6-byte commands without retiring → io_count = 2, drop_count = 1, no irq after the third command's last byte; dma_nak → io_count = 1, irq unchanged.
- Target 5 disabled (enable = 8'hDF): din 8'hA0 plus five bytes → irq never set, io_valid stays 0.
- Abort: start a 6-byte command, send 3 bytes, then a1=0 din 8'h03 plus five bytes → exactly one entry queued, byte0 = 8'h03.
- Apply reset_n = 0 while two entries are queued and irq = 1 → next cycle io_valid = 0, io_count = 0, irq = 0, drop_count = 0.
